song_player: RTL

SONG_PLAYER -- requirements
Module: song_player

---
 rtl/song_pkg.sv | 102 ++++++++++
 rtl/song_player_if.sv | 22 ++
 rtl/song_rom.sv | 26 ++
 rtl/song_player.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared note codes, ROM entry layout, FSM states and the two built-in tunes.
package song_pkg;

    localparam logic [3:0] NOTE_C4   = 4'd0;
    localparam logic [3:0] NOTE_D    = 4'd1;
    localparam logic [3:0] NOTE_E    = 4'd2;
    localparam logic [3:0] NOTE_F    = 4'd3;
    localparam logic [3:0] NOTE_G    = 4'd4;
    localparam logic [3:0] NOTE_A    = 4'd5;
    localparam logic [3:0] NOTE_B    = 4'd6;
    localparam logic [3:0] NOTE_C5   = 4'd7;
    localparam logic [3:0] NOTE_REST = 4'hF;

    localparam int unsigned NOTE_W  = 4;
    localparam int unsigned DUR_W   = 4;
    localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

    // Packed so that note occupies [7:4] and dur occupies [3:0].
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam entry_t END_MARK = '{note: NOTE_REST, dur: 4'd0};

    function automatic entry_t mk_entry(input logic [3:0] n, input logic [3:0] d);
        entry_t e;
        e.note = n;
        e.dur  = d;
        return e;
    endfunction

    function automatic entry_t ode_entry(input int unsigned idx);
        entry_t e;
        e = END_MARK;
        case (idx)
            0:  e = mk_entry(NOTE_E, 4'd2);
            1:  e = mk_entry(NOTE_E, 4'd1);
            2:  e = mk_entry(NOTE_F, 4'd1);
            3:  e = mk_entry(NOTE_G, 4'd2);
            4:  e = mk_entry(NOTE_G, 4'd1);
            5:  e = mk_entry(NOTE_F, 4'd1);
            6:  e = mk_entry(NOTE_E, 4'd1);
            7:  e = mk_entry(NOTE_D, 4'd1);
            8:  e = mk_entry(NOTE_C4, 4'd1);
            9:  e = mk_entry(NOTE_C4, 4'd1);
            10: e = mk_entry(NOTE_D, 4'd1);
            11: e = mk_entry(NOTE_E, 4'd1);
            12: e = mk_entry(NOTE_E, 4'd3);
            13: e = mk_entry(NOTE_D, 4'd1);
            14: e = mk_entry(NOTE_D, 4'd4);
            default: e = END_MARK;
        endcase
        return e;
    endfunction

    function automatic entry_t doremi_entry(input int unsigned idx);
        entry_t e;
        e = END_MARK;
        case (idx)
            0:  e = mk_entry(NOTE_C4, 4'd3);
            1:  e = mk_entry(NOTE_D, 4'd1);
            2:  e = mk_entry(NOTE_E, 4'd3);
            3:  e = mk_entry(NOTE_C4, 4'd1);
            4:  e = mk_entry(NOTE_E, 4'd2);
            5:  e = mk_entry(NOTE_C4, 4'd2);
            6:  e = mk_entry(NOTE_E, 4'd4);
            7:  e = mk_entry(NOTE_D, 4'd3);
            8:  e = mk_entry(NOTE_E, 4'd1);
            9:  e = mk_entry(NOTE_F, 4'd1);
            10: e = mk_entry(NOTE_F, 4'd1);
            11: e = mk_entry(NOTE_E, 4'd1);
            12: e = mk_entry(NOTE_D, 4'd1);
            13: e = mk_entry(NOTE_F, 4'd4);
            default: e = END_MARK;
        endcase
        return e;
    endfunction

    // Any code outside the piano range is played as silence.
    function automatic logic [3:0] legal_note(input logic [3:0] n);
        return (n <= 4'd7 || n == NOTE_REST) ? n : NOTE_REST;
    endfunction

    function automatic logic [7:0] note_onehot(input logic [3:0] n);
        logic [7:0] oh;
        oh = '0;
        if (n <= 4'd7) begin
            oh[n[2:0]] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/song_player_if.sv
// Control strobes in, note/status out, between a sequencer and the song player.
interface song_player_if;
    logic       QUARTER_BEAT;
    logic       START;
    logic       STOP;
    logic       LOOP;
    logic       SONG_SEL;
    logic [3:0] note;
    logic [7:0] Led;
    logic       busy;
    logic       done;

    modport master (
        output QUARTER_BEAT, START, STOP, LOOP, SONG_SEL,
        input  note, Led, busy, done
    );

    modport slave (
        input  QUARTER_BEAT, START, STOP, LOOP, SONG_SEL,
        output note, Led, busy, done
    );
endinterface

// File: rtl/song_rom.sv
// Song table lookup with a registered 8-bit entry output.
module song_rom
    import song_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          CLK,
    input  logic          song,
    input  logic [AW-1:0] addr,
    output entry_t        entry
);

    entry_t entry_d;
    entry_t entry_q;

    always_comb begin
        entry_d = song ? doremi_entry(32'(addr)) : ode_entry(32'(addr));
    end

    always_ff @(posedge CLK) begin
        entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/song_player.sv
// Song sequencer: walks a ROM tune at QUARTER_BEAT tempo and drives note/Led.
module song_player
    import song_pkg::*;
#(
    parameter int unsigned SONG_LEN_MAX = 32,
    parameter bit          GAP_EN       = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    song_player_if.slave bus
);

    localparam int unsigned   AW        = (SONG_LEN_MAX > 1) ? $clog2(SONG_LEN_MAX) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SONG_LEN_MAX - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          past_end_q, past_end_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic [3:0]    dur_q, dur_d;
    logic [3:0]    note_q, note_d;
    logic [7:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          song_q, song_d;

    logic [AW-1:0] next_addr;
    logic          next_past_end;
    entry_t        entry;

    // Fed with the next-state address so the entry is ready during LOAD.
    song_rom #(.AW(AW)) u_rom (
        .CLK   (CLK),
        .song  (song_d),
        .addr  (addr_d),
        .entry (entry)
    );

    // Stepping past the last slot flags end-of-song instead of overflowing addr.
    always_comb begin
        next_past_end = (addr_q == LAST_ADDR);
        next_addr     = next_past_end ? '0 : addr_q + AW'(1);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        past_end_d = past_end_q;
        beat_cnt_d = beat_cnt_q;
        dur_d      = dur_q;
        note_d     = note_q;
        song_d     = song_q;
        done_d     = 1'b0;

        if (bus.STOP) begin
            state_d    = ST_IDLE;
            addr_d     = '0;
            past_end_d = 1'b0;
            beat_cnt_d = '0;
            note_d     = NOTE_REST;
        end else if (bus.START) begin
            state_d    = ST_LOAD;
            addr_d     = '0;
            past_end_d = 1'b0;
            song_d     = bus.SONG_SEL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    note_d = NOTE_REST;
                end
                ST_LOAD: begin
                    if (past_end_q || entry.dur == '0) begin
                        addr_d     = '0;
                        past_end_d = 1'b0;
                        if (bus.LOOP) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            note_d  = NOTE_REST;
                        end
                    end else begin
                        state_d    = ST_PLAY;
                        note_d     = legal_note(entry.note);
                        dur_d      = entry.dur;
                        beat_cnt_d = '0;
                    end
                end
                ST_PLAY: begin
                    if (bus.QUARTER_BEAT) begin
                        if (beat_cnt_q + 4'd1 == dur_q) begin
                            beat_cnt_d = '0;
                            if (GAP_EN && dur_q >= 4'd2) begin
                                state_d = ST_GAP;
                                note_d  = NOTE_REST;
                            end else begin
                                state_d    = ST_LOAD;
                                addr_d     = next_addr;
                                past_end_d = next_past_end;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    note_d = NOTE_REST;
                    if (bus.QUARTER_BEAT) begin
                        state_d    = ST_LOAD;
                        addr_d     = next_addr;
                        past_end_d = next_past_end;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_REST;
                end
                default: begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_REST;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        led_d  = note_onehot(note_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            past_end_q <= 1'b0;
            beat_cnt_q <= '0;
            dur_q      <= '0;
            note_q     <= NOTE_REST;
            led_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            song_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            past_end_q <= past_end_d;
            beat_cnt_q <= beat_cnt_d;
            dur_q      <= dur_d;
            note_q     <= note_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            song_q     <= song_d;
        end
    end

    assign bus.note = note_q;
    assign bus.Led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
